// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment glyph constants and segment bit order
package seg7_pkg;

    // Segment bit positions within the {g,f,e,d,c,b,a} glyph word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_LOCK  = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_LOCK = 4'hA;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit code to active-high {g,f,e,d,c,b,a} glyph
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'd0:      glyph = SEG_0;
            4'd1:      glyph = SEG_1;
            4'd2:      glyph = SEG_2;
            4'd3:      glyph = SEG_3;
            4'd4:      glyph = SEG_4;
            4'd5:      glyph = SEG_5;
            4'd6:      glyph = SEG_6;
            4'd7:      glyph = SEG_7;
            4'd8:      glyph = SEG_8;
            4'd9:      glyph = SEG_9;
            CODE_LOCK: glyph = SEG_LOCK;
            default:   glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/led7seg_scan.sv
// rtl/led7seg_scan.sv - N-digit multiplexed seven-segment scanner
// Optional leading-zero blanking enabled by defining SEG7_LZB_EN.
module led7seg_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 1000,
    parameter int COMMON_ANODE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     dig,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic POL = (COMMON_ANODE != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] bcd_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  wrapped;
    logic [3:0]            nibble;
    logic                  dp_sel;
    logic [6:0]            glyph;
    logic [6:0]            seg_l;
    logic [N_DIGITS-1:0]   dig_l;
    logic                  guard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
            dp_q  <= '0;
        end else if (load) begin
            bcd_q <= bcd_in;
            dp_q  <= dp_in;
        end
    end

    // wrapped marks the cycle right after idx rolls over, so frame_tick
    // never fires on the first guard after reset or enable rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            wrapped <= 1'b0;
        end else if (!enable) begin
            cnt     <= '0;
            idx     <= '0;
            wrapped <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            wrapped <= (idx == IDX_LAST);
        end else begin
            cnt     <= cnt + 1'b1;
            wrapped <= 1'b0;
        end
    end

    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble = bcd_q[4*i +: 4];
                dp_sel = dp_q[i];
            end
        end
    end

    seg7_decode u_decode (
        .code  (nibble),
        .glyph (glyph)
    );

`ifdef SEG7_LZB_EN
    logic blank;

    // Blank when every code at or above this digit is zero; digit 0 always shows.
    always_comb begin
        blank = (idx != '0);
        for (int i = 0; i < N_DIGITS; i++) begin
            if (i >= int'(idx) && bcd_q[4*i +: 4] != 4'h0) begin
                blank = 1'b0;
            end
        end
    end

    assign seg_l = blank ? SEG_BLANK : glyph;
`else
    assign seg_l = glyph;
`endif

    always_comb begin
        dig_l = N_DIGITS'(1) << idx;
        guard = (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{POL}};
            dp         <= POL;
            dig        <= {N_DIGITS{~POL}};
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= enable & guard & wrapped;
            if (!enable || guard) begin
                seg <= {7{POL}};
                dp  <= POL;
                dig <= {N_DIGITS{~POL}};
            end else begin
                seg <= seg_l ^ {7{POL}};
                dp  <= dp_sel ^ POL;
                dig <= dig_l ^ {N_DIGITS{~POL}};
            end
        end
    end

endmodule

// File: tb/tb_led7seg_scan.sv
// tb/tb_led7seg_scan.sv - self-checking bench for led7seg_scan (both polarities)
module tb_led7seg_scan;

    localparam int N = 4;
    localparam int P = 4;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_a, seg_c;
    logic        dp_a, dp_c;
    logic [3:0]  dig_a, dig_c;
    logic        ft_a, ft_c;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h38, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    logic [6:0] cs [20];
    logic [3:0] cd [20];
    logic       cdp [20];
    logic       cft [20];
    logic [6:0] ccs [20];
    logic [3:0] ccd [20];

    always #5 clk = ~clk;

    led7seg_scan #(.N_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(0)) u_cc (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .bcd_in(bcd_in), .dp_in(dp_in),
        .seg(seg_a), .dp(dp_a), .dig(dig_a), .frame_tick(ft_a)
    );

    led7seg_scan #(.N_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(1)) u_ca (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .bcd_in(bcd_in), .dp_in(dp_in),
        .seg(seg_c), .dp(dp_c), .dig(dig_c), .frame_tick(ft_c)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos counts enabled cycles since scan start; slot/digit follow by arithmetic.
    initial begin
        int          pos;
        logic [15:0] m_bcd;
        logic [3:0]  m_dp;
        logic [6:0]  es, es_n;
        logic        edp, eft;
        logic [3:0]  edig, edig_n;
        int          slot, digit;
        pos = 0;
        m_bcd = '0;
        m_dp = '0;
        forever begin
            @(posedge clk);
            es = 7'h00;
            edp = 1'b0;
            edig = 4'h0;
            eft = 1'b0;
            if (!rst_n) begin
                pos = 0;
                m_bcd = '0;
                m_dp = '0;
            end else begin
                if (!enable) begin
                    pos = 0;
                end else begin
                    slot  = pos % P;
                    digit = (pos / P) % N;
                    eft   = (pos >= N * P) && (pos % (N * P) == 0);
                    if (slot != 0) begin
                        es = tbl[m_bcd[4*digit +: 4]];
                        if (LZB && digit > 0 && (m_bcd >> (4 * digit)) == 16'h0) es = 7'h00;
                        edp  = m_dp[digit];
                        edig = 4'(1 << digit);
                    end
                    pos++;
                end
                if (load) begin
                    m_bcd = bcd_in;
                    m_dp  = dp_in;
                end
            end
            es_n = ~es;
            edig_n = ~edig;
            #1;
            chk("seg_cc", {25'h0, seg_a}, {25'h0, es});
            chk("dp_cc", {31'h0, dp_a}, {31'h0, edp});
            chk("dig_cc", {28'h0, dig_a}, {28'h0, edig_n});
            chk("tick_cc", {31'h0, ft_a}, {31'h0, eft});
            chk("seg_ca", {25'h0, seg_c}, {25'h0, es_n});
            chk("dp_ca", {31'h0, dp_c}, {31'h0, ~edp});
            chk("dig_ca", {28'h0, dig_c}, {28'h0, edig});
            chk("tick_ca", {31'h0, ft_c}, {31'h0, eft});
        end
    end

    task automatic capture(input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            cs[p] = seg_a; cd[p] = dig_a; cdp[p] = dp_a; cft[p] = ft_a;
            ccs[p] = seg_c; ccd[p] = dig_c;
        end
    endtask

    task automatic restart(input logic [15:0] b, input logic [3:0] d);
        @(negedge clk);
        enable = 1'b0; load = 1'b1; bcd_in = b; dp_in = d;
        @(negedge clk);
        load = 1'b0; enable = 1'b1;
    endtask

    initial begin
        logic [6:0] lit_seg [17];
        logic [3:0] lit_dig [17];
        lit_seg = '{7'h00, 7'h66, 7'h66, 7'h66, 7'h00, 7'h4F, 7'h4F, 7'h4F, 7'h00,
                    7'h5B, 7'h5B, 7'h5B, 7'h00, 7'h06, 7'h06, 7'h06, 7'h00};
        lit_dig = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                    4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_seg_cc", {25'h0, seg_a}, 32'h00);
        chk("rst_dig_cc", {28'h0, dig_a}, 32'hF);
        chk("rst_seg_ca", {25'h0, seg_c}, 32'h7F);
        chk("rst_dp_ca", {31'h0, dp_c}, 32'h1);
        chk("rst_dig_ca", {28'h0, dig_c}, 32'h0);
        rst_n = 1'b1;

        restart(16'h1234, 4'b0000);
        capture(17);
        for (int p = 0; p < 17; p++) begin
            chk($sformatf("f1234_seg_%0d", p), {25'h0, cs[p]}, {25'h0, lit_seg[p]});
            chk($sformatf("f1234_dig_%0d", p), {28'h0, cd[p]}, {28'h0, lit_dig[p]});
            chk($sformatf("f1234_tick_%0d", p), {31'h0, cft[p]}, (p == 16) ? 32'h1 : 32'h0);
        end

        restart(16'h00A7, 4'b0000);
        capture(16);
        chk("a7_d0", {25'h0, cs[1]}, 32'h07);
        chk("a7_d1", {25'h0, cs[5]}, 32'h38);
        chk("a7_d2", {25'h0, cs[9]}, LZB ? 32'h00 : 32'h3F);
        chk("a7_d3", {25'h0, cs[13]}, LZB ? 32'h00 : 32'h3F);

        restart(16'h0000, 4'b0100);
        capture(16);
        chk("z_d0", {25'h0, cs[1]}, 32'h3F);
        chk("z_d1", {25'h0, cs[5]}, LZB ? 32'h00 : 32'h3F);
        chk("z_d2_seg", {25'h0, cs[9]}, LZB ? 32'h00 : 32'h3F);
        chk("z_d2_dp", {31'h0, cdp[9]}, 32'h1);
        chk("z_d2_dig", {28'h0, cd[9]}, 32'hB);

        restart(16'h0008, 4'b0000);
        capture(4);
        chk("ca8_seg", {25'h0, ccs[1]}, 32'h00);
        chk("ca8_dig", {28'h0, ccd[1]}, 32'h1);

        restart(16'h9999, 4'b0000);
        capture(11);
        chk("n9_guard", {25'h0, cs[0]}, 32'h00);
        chk("n9_first", {25'h0, cs[1]}, 32'h6F);
        chk("n9_d2_dig", {28'h0, cd[10]}, 32'hB);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", {25'h0, seg_a}, 32'h00);
        chk("mid_rst_dig", {28'h0, dig_a}, 32'hF);
        chk("mid_rst_seg_ca", {25'h0, seg_c}, 32'h7F);
        chk("mid_rst_tick", {31'h0, ft_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        capture(17);
        chk("post_rst_guard", {28'h0, cd[0]}, 32'hF);
        chk("post_rst_d0", {25'h0, cs[1]}, 32'h3F);
        chk("post_rst_notick", {31'h0, cft[0]}, 32'h0);
        chk("post_rst_tick16", {31'h0, cft[16]}, 32'h1);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            load = ($urandom % 8) == 0;
            for (int k = 0; k < N; k++) begin
                bcd_in[4*k +: 4] = (($urandom % 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            dp_in = 4'($urandom);
            if (($urandom % 150) == 0) enable = ~enable;
            rst_n = (($urandom % 400) == 0) ? 1'b0 : 1'b1;
            if (!enable && ($urandom % 4) == 0) enable = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1; load = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
